// File: rtl/gr8b0nd_pkg.sv
// Shared definitions for the ALU execute sequencer: opcode constants,
// instruction field positions, FSM state encoding and decode helpers.
package gr8b0nd_pkg;

  // Top-nibble opcodes of the immediate-format instructions
  localparam logic [3:0] TOP_CI8     = 4'hB;
  localparam logic [3:0] TOP_CII     = 4'hC;
  localparam logic [3:0] TOP_CUP     = 4'hD;
  localparam logic [3:0] TOP_BZ      = 4'hE;
  localparam logic [3:0] TOP_BNZ     = 4'hF;
  localparam logic [3:0] TOP_IMM_MIN = 4'hB;

  // Full 8-bit opcodes of the register-format instructions with special handling
  localparam logic [7:0] OP_TRAP = 8'h00;
  localparam logic [7:0] OP_JR   = 8'h01;
  localparam logic [7:0] OP_LD   = 8'h40;
  localparam logic [7:0] OP_ST   = 8'h41;

  // Field LSB positions inside the 16-bit instruction word
  localparam int TOP_LSB = 12;
  localparam int OP_LSB  = 8;
  localparam int IMM_LSB = 4;
  localparam int RS_LSB  = 4;
  localparam int RD_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // What the writeback cycle stores into R[rd]
  typedef enum logic [2:0] {
    WB_NONE   = 3'd0,
    WB_RESULT = 3'd1,
    WB_CI8    = 3'd2,
    WB_CII    = 3'd3,
    WB_CUP    = 3'd4
  } wb_kind_t;

  // True for op8 values that are executed by the external ALU
  function automatic logic is_alu_op(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    if (op >= 8'h70 && op <= 8'h77) begin
      hit = 1'b1;
    end else if (op >= 8'h60 && op <= 8'h63) begin
      hit = 1'b1;
    end else if (op >= 8'h50 && op <= 8'h52) begin
      hit = 1'b1;
    end else if (op == 8'h32 || op == 8'h33 || op == 8'h10) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // True when the top nibble selects the imm8/rd instruction format
  function automatic logic is_imm_top(input logic [3:0] top);
    return (top >= TOP_IMM_MIN);
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake from fetch plus the load/store memory handshake.
// master = sequencer side, slave = fetch stage / data memory side.
interface alu_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [15:0]      in_instr;
  logic             in_ready;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ack;

  modport master (
    input  in_valid, in_instr, mem_rdata, mem_ack,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_instr, mem_rdata, mem_ack,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/gr8b0nd_regfile.sv
// Register file: one synchronous write port, three combinational read ports
// (source operand, destination operand, debug) and a synchronous clear.
module gr8b0nd_regfile #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    rs_addr,
  output logic [WIDTH-1:0] rs_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs_r [NREGS];

  // Storage update: clear everything on reset, otherwise single-port write
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rs_data  = regs_r[rs_addr];
  assign rd_data  = regs_r[rd_addr];
  assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle execute controller: accepts an instruction, reads operands,
// drives the external ALU or the memory handshake, then retires with a
// one-cycle done pulse and an optional register write.
module alu_sequencer
  import gr8b0nd_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_sequencer_if.master   bus,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [7:0]        alu_sel,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_carry,
  output logic              done,
  output logic              br_taken,
  output logic [WIDTH-1:0]  br_target,
  output logic              carry_flag,
  output logic              illegal,
  output logic              halted,
  input  logic [3:0]        dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t           state_r;
  wb_kind_t         wb_kind_r;
  logic [15:0]      instr_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] result_r;
  logic             in_ready_r;
  logic             mem_req_r;
  logic             mem_we_r;
  logic [WIDTH-1:0] mem_addr_r;
  logic [WIDTH-1:0] mem_wdata_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [7:0]       alu_sel_r;
  logic             done_r;
  logic             br_taken_r;
  logic [WIDTH-1:0] br_target_r;
  logic             carry_flag_r;
  logic             illegal_r;
  logic             halted_r;

  logic [3:0]       top_s;
  logic [7:0]       op8_s;
  logic [7:0]       imm8_s;
  logic [AW-1:0]    rs_s;
  logic [AW-1:0]    rd_s;
  logic [WIDTH-1:0] rs_data_s;
  logic [WIDTH-1:0] rd_data_s;
  logic             wr_en_s;
  logic [WIDTH-1:0] wr_data_s;

  assign top_s  = instr_r[TOP_LSB +: 4];
  assign op8_s  = instr_r[OP_LSB +: 8];
  assign imm8_s = instr_r[IMM_LSB +: 8];
  assign rs_s   = instr_r[RS_LSB +: AW];
  assign rd_s   = instr_r[RD_LSB +: AW];

  gr8b0nd_regfile #(
    .NREGS (NREGS),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .clr_n    (rst_n),
    .we       (wr_en_s),
    .waddr    (rd_s),
    .wdata    (wr_data_s),
    .rs_addr  (rs_s),
    .rs_data  (rs_data_s),
    .rd_addr  (rd_s),
    .rd_data  (rd_data_s),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Writeback data selection; the write itself lands on the edge that leaves WB
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = '0;
    if (state_r == ST_WB) begin
      case (wb_kind_r)
        WB_RESULT: begin wr_en_s = 1'b1; wr_data_s = result_r;                 end
        WB_CI8:    begin wr_en_s = 1'b1; wr_data_s = sext8(imm8_s);            end
        WB_CII:    begin wr_en_s = 1'b1; wr_data_s = {imm8_s, imm8_s};         end
        WB_CUP:    begin wr_en_s = 1'b1; wr_data_s = {imm8_s, op_b_r[7:0]};    end
        default:   begin wr_en_s = 1'b0; wr_data_s = '0;                       end
      endcase
    end else begin
      wr_en_s   = 1'b0;
      wr_data_s = '0;
    end
  end

  // Sequencer FSM with all outputs registered; pulses default low each cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      wb_kind_r    <= WB_NONE;
      instr_r      <= 16'h0000;
      op_b_r       <= '0;
      result_r     <= '0;
      in_ready_r   <= 1'b1;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      alu_a_r      <= '0;
      alu_b_r      <= '0;
      alu_sel_r    <= 8'h00;
      done_r       <= 1'b0;
      br_taken_r   <= 1'b0;
      br_target_r  <= '0;
      carry_flag_r <= 1'b0;
      illegal_r    <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      illegal_r   <= 1'b0;
      br_taken_r  <= 1'b0;
      br_target_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            instr_r    <= bus.in_instr;
            in_ready_r <= 1'b0;
            state_r    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_b_r <= rd_data_s;
          if (is_imm_top(top_s)) begin
            state_r <= ST_WB;
            done_r  <= 1'b1;
            case (top_s)
              TOP_CI8: wb_kind_r <= WB_CI8;
              TOP_CII: wb_kind_r <= WB_CII;
              TOP_CUP: wb_kind_r <= WB_CUP;
              TOP_BZ: begin
                wb_kind_r   <= WB_NONE;
                br_taken_r  <= (rd_data_s == '0);
                br_target_r <= sext8(imm8_s);
              end
              TOP_BNZ: begin
                wb_kind_r   <= WB_NONE;
                br_taken_r  <= (rd_data_s != '0);
                br_target_r <= sext8(imm8_s);
              end
              default: wb_kind_r <= WB_NONE;
            endcase
          end else if (is_alu_op(op8_s)) begin
            state_r   <= ST_EXEC;
            wb_kind_r <= WB_RESULT;
            alu_a_r   <= rs_data_s;
            alu_b_r   <= rd_data_s;
            alu_sel_r <= op8_s;
          end else if (op8_s == OP_LD || op8_s == OP_ST) begin
            state_r     <= ST_MEM;
            wb_kind_r   <= (op8_s == OP_LD) ? WB_RESULT : WB_NONE;
            mem_req_r   <= 1'b1;
            mem_we_r    <= (op8_s == OP_ST);
            mem_addr_r  <= rs_data_s;
            mem_wdata_r <= rd_data_s;
          end else if (op8_s == OP_TRAP) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end else if (op8_s == OP_JR) begin
            state_r     <= ST_WB;
            wb_kind_r   <= WB_NONE;
            done_r      <= 1'b1;
            br_taken_r  <= 1'b1;
            br_target_r <= rd_data_s;
          end else begin
            state_r   <= ST_WB;
            wb_kind_r <= WB_NONE;
            done_r    <= 1'b1;
            illegal_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          result_r     <= alu_out;
          carry_flag_r <= alu_carry;
          alu_a_r      <= '0;
          alu_b_r      <= '0;
          alu_sel_r    <= 8'h00;
          state_r      <= ST_WB;
          done_r       <= 1'b1;
        end
        ST_MEM: begin
          if (bus.mem_ack) begin
            if (!mem_we_r) begin
              result_r <= bus.mem_rdata;
            end
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            state_r     <= ST_WB;
            done_r      <= 1'b1;
          end
        end
        ST_WB: begin
          wb_kind_r  <= WB_NONE;
          in_ready_r <= 1'b1;
          state_r    <= ST_IDLE;
        end
        ST_HALT: begin
          in_ready_r <= 1'b0;
          halted_r   <= 1'b1;
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_sel       = alu_sel_r;
  assign done          = done_r;
  assign br_taken      = br_taken_r;
  assign br_target     = br_target_r;
  assign carry_flag    = carry_flag_r;
  assign illegal       = illegal_r;
  assign halted        = halted_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, hand-written
// trap / mid-operation reset sequences and randomized instruction streams
// checked against an instruction-level reference model.
`timescale 1ns/10ps
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] alu_a, alu_b, alu_out, br_target, dbg_data;
  logic [7:0]  alu_sel;
  logic        alu_carry, done, br_taken, carry_flag, illegal, halted;
  logic [3:0]  dbg_addr;

  int tests = 0;
  int fails = 0;

  logic [15:0] mregs [16];
  logic        mcarry;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(16)) bus ();

  alu_sequencer #(.NREGS(16), .WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .done(done), .br_taken(br_taken), .br_target(br_target),
    .carry_flag(carry_flag), .illegal(illegal), .halted(halted),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // External ALU model: add / subtract / xor / and chosen by sel[1:0]
  function automatic logic [16:0] alu_fn(input logic [7:0] sel, input logic [15:0] a, input logic [15:0] b);
    case (sel[1:0])
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a} - {1'b0, b};
      2'd2:    return {1'b0, a ^ b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_fn(alu_sel, alu_a, alu_b);

  typedef struct {
    int lat; bit wr; int wreg; logic [15:0] wval;
    bit br; bit taken; logic [15:0] target; bit illegal;
    bit alu; logic [7:0] sel; logic [15:0] a, b; bit carry_upd; bit carry;
    bit mem; bit we; logic [15:0] addr, wdata; int delay;
  } exp_t;

  typedef struct {
    bit timeout; int lat; bit taken; logic [15:0] target; bit illegal; int ill_cycles;
    int alu_cycles; logic [7:0] sel; logic [15:0] a, b;
    int req_cycles; bit we; logic [15:0] addr, wdata; bit unstable;
    bit done_after; bit ready_after;
  } obs_t;

  typedef struct {
    logic [15:0] instr; int delay; logic [15:0] rdata;
    int lat; bit br; bit taken; logic [15:0] target; bit illegal;
    int wreg; logic [15:0] wval; bit carry;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #0.25;
      check($sformatf("%s R%0d", tag, i), dbg_data, mregs[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0000;
    mcarry = 1'b0;
  endtask

  // Instruction-level reference: what one instruction must do, from the ISA rules
  function automatic exp_t predict(input logic [15:0] instr, input logic [15:0] rdata, input int delay);
    exp_t e;
    logic [3:0] top;
    logic [7:0] op, imm;
    logic [15:0] va, vb, sx;
    logic [16:0] r;
    int rs, rd;
    e = '{default: 0};
    top = instr[15:12]; op = instr[15:8]; imm = instr[11:4];
    rs = int'(instr[7:4]); rd = int'(instr[3:0]);
    va = mregs[rs]; vb = mregs[rd];
    sx = {{8{imm[7]}}, imm};
    e.delay = delay;
    if (top >= 4'hB) begin
      e.lat = 2;
      case (top)
        4'hB: begin e.wr = 1; e.wreg = rd; e.wval = sx; end
        4'hC: begin e.wr = 1; e.wreg = rd; e.wval = {imm, imm}; end
        4'hD: begin e.wr = 1; e.wreg = rd; e.wval = {imm, vb[7:0]}; end
        4'hE: begin e.br = 1; e.taken = (vb == 16'h0); e.target = sx; end
        default: begin e.br = 1; e.taken = (vb != 16'h0); e.target = sx; end
      endcase
    end else if (op inside {[8'h70:8'h77], [8'h60:8'h63], [8'h50:8'h52], 8'h32, 8'h33, 8'h10}) begin
      r = alu_fn(op, va, vb);
      e.lat = 3; e.alu = 1; e.sel = op; e.a = va; e.b = vb;
      e.wr = 1; e.wreg = rd; e.wval = r[15:0]; e.carry_upd = 1; e.carry = r[16];
    end else if (op == 8'h40 || op == 8'h41) begin
      e.lat = delay + 2; e.mem = 1; e.we = (op == 8'h41); e.addr = va; e.wdata = vb;
      if (op == 8'h40) begin e.wr = 1; e.wreg = rd; e.wval = rdata; end
    end else if (op == 8'h01) begin
      e.lat = 2; e.br = 1; e.taken = 1; e.target = vb;
    end else begin
      e.lat = 2; e.illegal = 1;
    end
    return e;
  endfunction

  task automatic apply(input exp_t e);
    if (e.wr) mregs[e.wreg] = e.wval;
    if (e.carry_upd) mcarry = e.carry;
  endtask

  // Issue one instruction from a negedge and watch it to retirement
  task automatic run_instr(input logic [15:0] instr, input int delay, input logic [15:0] rdata, output obs_t o);
    int n;
    bit seen;
    o = '{default: 0};
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_instr = 16'($urandom);
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 16'($urandom);
      if (alu_sel != 8'h00) begin
        o.alu_cycles++; o.sel = alu_sel; o.a = alu_a; o.b = alu_b;
      end
      if (bus.mem_req) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.addr = bus.mem_addr; o.we = bus.mem_we; o.wdata = bus.mem_wdata;
        end else if (o.addr !== bus.mem_addr || o.we !== bus.mem_we || o.wdata !== bus.mem_wdata) begin
          o.unstable = 1;
        end
        if (o.req_cycles == delay) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = rdata;
        end
      end
      if (illegal) o.ill_cycles++;
      if (done) begin
        seen = 1; o.lat = n; o.taken = br_taken; o.target = br_target; o.illegal = illegal;
      end
    end
    o.timeout = !seen;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    o.done_after = done;
    o.ready_after = bus.in_ready;
  endtask

  task automatic compare_model(input string tag, input obs_t o, input exp_t e);
    check({tag, " timeout"}, o.timeout, 0);
    check({tag, " latency"}, o.lat, e.lat);
    check({tag, " br_taken"}, o.taken, e.taken);
    if (e.br) check({tag, " br_target"}, o.target, e.target);
    check({tag, " illegal"}, o.illegal, e.illegal);
    check({tag, " illegal cycles"}, o.ill_cycles, e.illegal);
    check({tag, " alu_sel cycles"}, o.alu_cycles, e.alu);
    if (e.alu) begin
      check({tag, " alu_sel"}, o.sel, e.sel);
      check({tag, " alu_a"}, o.a, e.a);
      check({tag, " alu_b"}, o.b, e.b);
    end
    check({tag, " mem_req cycles"}, o.req_cycles, e.mem ? e.delay : 0);
    if (e.mem) begin
      check({tag, " mem_addr"}, o.addr, e.addr);
      check({tag, " mem_we"}, o.we, e.we);
      check({tag, " mem_wdata"}, o.wdata, e.wdata);
      check({tag, " mem stable"}, o.unstable, 0);
    end
    check({tag, " done pulse width"}, o.done_after, 0);
    check({tag, " in_ready after"}, o.ready_after, 1);
    check({tag, " carry_flag"}, carry_flag, mcarry);
    check_regs(tag);
  endtask

  // Random instruction mix biased toward the defined opcode groups
  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    logic [7:0]  lo;
    lo = 8'($urandom);
    case ($urandom_range(0, 5))
      0: w = {4'(11 + $urandom_range(0, 4)), 12'($urandom)};
      1: w = {8'h70 + 8'($urandom_range(0, 7)), lo};
      2: begin
        case ($urandom_range(0, 2))
          0: w = {8'h60 + 8'($urandom_range(0, 3)), lo};
          1: w = {8'h50 + 8'($urandom_range(0, 2)), lo};
          default: w = {8'h32 + 8'($urandom_range(0, 1)), lo};
        endcase
      end
      3: w = {8'h40 + 8'($urandom_range(0, 1)), lo};
      4: w = {8'h01, lo};
      default: w = 16'($urandom);
    endcase
    if (w[15:8] == 8'h00) w[15:8] = 8'h10;
    return w;
  endfunction

  vec_t vecs[$];

  initial begin
    obs_t o;
    exp_t e;
    int dcount;
    string tag;

    vecs.push_back('{16'hBF61, 0, 16'h0,    2, 0, 0, 16'h0,    0,  1, 16'hFFF6, 0});
    vecs.push_back('{16'hC0A2, 0, 16'h0,    2, 0, 0, 16'h0,    0,  2, 16'h0A0A, 0});
    vecs.push_back('{16'hD122, 0, 16'h0,    2, 0, 0, 16'h0,    0,  2, 16'h120A, 0});
    vecs.push_back('{16'hB091, 0, 16'h0,    2, 0, 0, 16'h0,    0,  1, 16'h0009, 0});
    vecs.push_back('{16'hB002, 0, 16'h0,    2, 0, 0, 16'h0,    0,  2, 16'h0000, 0});
    vecs.push_back('{16'h7012, 0, 16'h0,    3, 0, 0, 16'h0,    0,  2, 16'h0009, 0});
    vecs.push_back('{16'hBFF1, 0, 16'h0,    2, 0, 0, 16'h0,    0,  1, 16'hFFFF, 0});
    vecs.push_back('{16'hB012, 0, 16'h0,    2, 0, 0, 16'h0,    0,  2, 16'h0001, 0});
    vecs.push_back('{16'h7012, 0, 16'h0,    3, 0, 0, 16'h0,    0,  2, 16'h0000, 1});
    vecs.push_back('{16'hB003, 0, 16'h0,    2, 0, 0, 16'h0,    0,  3, 16'h0000, 1});
    vecs.push_back('{16'hEFC3, 0, 16'h0,    2, 1, 1, 16'hFFFC, 0, -1, 16'h0000, 1});
    vecs.push_back('{16'hFFC3, 0, 16'h0,    2, 1, 0, 16'hFFFC, 0, -1, 16'h0000, 1});
    vecs.push_back('{16'hB403, 0, 16'h0,    2, 0, 0, 16'h0,    0,  3, 16'h0040, 1});
    vecs.push_back('{16'h0103, 0, 16'h0,    2, 1, 1, 16'h0040, 0, -1, 16'h0000, 1});
    vecs.push_back('{16'hB004, 0, 16'h0,    2, 0, 0, 16'h0,    0,  4, 16'h0000, 1});
    vecs.push_back('{16'hD014, 0, 16'h0,    2, 0, 0, 16'h0,    0,  4, 16'h0100, 1});
    vecs.push_back('{16'h4045, 3, 16'hBEEF, 5, 0, 0, 16'h0,    0,  5, 16'hBEEF, 1});
    vecs.push_back('{16'h4145, 1, 16'h0,    3, 0, 0, 16'h0,    0, -1, 16'h0000, 1});
    vecs.push_back('{16'h3012, 0, 16'h0,    2, 0, 0, 16'h0,    1, -1, 16'h0000, 1});

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = 16'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
    dbg_addr = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset in_ready", bus.in_ready, 1);
    check("reset done", done, 0);
    check("reset mem_req", bus.mem_req, 0);
    check("reset alu_sel", alu_sel, 0);
    check("reset halted", halted, 0);
    check("reset carry_flag", carry_flag, 0);
    check("reset illegal", illegal, 0);
    check("reset br_taken", br_taken, 0);
    check_regs("reset");

    // Directed vector table
    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d %h", i, vecs[i].instr);
      e = predict(vecs[i].instr, vecs[i].rdata, vecs[i].delay);
      run_instr(vecs[i].instr, vecs[i].delay, vecs[i].rdata, o);
      apply(e);
      compare_model(tag, o, e);
      check({tag, " tbl latency"}, o.lat, vecs[i].lat);
      check({tag, " tbl br_taken"}, o.taken, vecs[i].taken);
      if (vecs[i].br) check({tag, " tbl br_target"}, o.target, vecs[i].target);
      check({tag, " tbl illegal"}, o.illegal, vecs[i].illegal);
      check({tag, " tbl carry"}, carry_flag, vecs[i].carry);
      if (vecs[i].wreg >= 0) begin
        dbg_addr = 4'(vecs[i].wreg);
        #0.25;
        check({tag, " tbl write"}, dbg_data, vecs[i].wval);
      end
    end

    // Stray ack while idle is ignored, then a normal load still waits for its own ack
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    e = predict(16'h4046, 16'h5A5A, 2);
    run_instr(16'h4046, 2, 16'h5A5A, o);
    apply(e);
    compare_model("stray ack ld", o, e);

    // Trap: halted, never ready again until reset, no done pulse
    bus.in_valid = 1'b1; bus.in_instr = 16'h0000;
    @(posedge clk);
    #1 bus.in_instr = 16'hB011;
    dcount = 0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (done) dcount++;
      check($sformatf("halt in_ready c%0d", k), bus.in_ready, 0);
      if (k >= 2) check($sformatf("halt halted c%0d", k), halted, 1);
    end
    check("halt no done", dcount, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("halt reset halted", halted, 0);
    check("halt reset in_ready", bus.in_ready, 1);
    check_regs("halt reset");

    // Mid-operation reset during MEM: request drops, no writeback
    e = predict(16'hB224, 16'h0, 0);
    run_instr(16'hB224, 0, 16'h0, o);
    apply(e);
    compare_model("setup r4", o, e);
    bus.in_valid = 1'b1; bus.in_instr = 16'h4045;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst mem_req before", bus.mem_req, 1);
    rst_n = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b0;
    model_reset();
    check("midrst mem_req", bus.mem_req, 0);
    check("midrst in_ready", bus.in_ready, 1);
    check("midrst done", done, 0);
    dcount = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst no done", dcount, 0);
    check_regs("midrst");

    // Randomized stream against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [15:0] ins, rd_val;
      int dly;
      ins = rand_instr();
      dly = $urandom_range(1, 4);
      rd_val = 16'($urandom);
      tag = $sformatf("rnd%0d %h", i, ins);
      e = predict(ins, rd_val, dly);
      run_instr(ins, dly, rd_val, o);
      apply(e);
      compare_model(tag, o, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multicycle execute controller for the 16-bit ALU.
- Accepts one instruction word per valid/ready handshake and decodes it. Reads operands from an internal 16x16 register file, drives the external ALU, sequences a load/store memory handshake, and writes back.
- Sits between the fetch stage (instruction source, PC owner) and the ALU/data memory.

Parameters:
- NREGS, 16, register-file depth; rd/rs fields are 4 bits wide.
- WIDTH, 16, datapath word width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  instruction word present.
- in_instr  in  16  instruction word.
- in_ready  out  1  sequencer can accept an instruction.
- alu_a  out  16  ALU source operand: R[rs].
- alu_b  out  16  ALU destination operand: R[rd].
- alu_sel  out  8  ALU select, equal to in_instr[15:8].
- alu_out  in  16  ALU result (combinational).
- alu_carry  in  1  ALU carry-out.
- mem_req  out  1  memory request; held until ack.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  16  R[rs].
- mem_wdata  out  16  R[rd].
- mem_rdata  in  16  load data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion.
- done  out  1  one-cycle pulse at writeback/retire.
- br_taken  out  1  valid with done.
- br_target  out  16  signed offset for bz/bnz; absolute target for jr.
- carry_flag  out  1  last captured alu_carry.
- illegal  out  1  one-cycle pulse, coincident with done.
- halted  out  1  trap seen.
- dbg_addr  in  4  debug read index.
- dbg_data  out  16  R[dbg_addr]; combinational read.

Behaviour:
- Decode:
  - Top = in_instr[15:12].
  - Top in {b,c,d,e,f}: imm8 = [11:4], rd = [3:0].
  - Otherwise op8 = [15:8], rs = [7:4], rd = [3:0].
- States: IDLE, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - in_ready = 1 only in IDLE.
  - On in_valid & in_ready: latch instr; go to DECODE.
- DECODE: latch opA = R[rs] and opB = R[rd], then go to:
  - EXEC for ALU ops: 0x70-0x77, 0x60-0x63, 0x50-0x52, 0x32, 0x33, 0x10.
  - MEM for 0x40 (ld) and 0x41 (st).
  - HALT for 0x00 (trap).
  - WB for everything else.
- EXEC (one cycle):
  - alu_a = opA, alu_b = opB, alu_sel = op8; outside EXEC alu_sel = 0x00.
  - Capture alu_out to result and alu_carry to carry_flag; go to WB.
- MEM:
  - mem_req = 1 with stable addr/we/wdata until mem_ack is sampled high.
  - ld captures mem_rdata; then go to WB.
  - mem_ack outside MEM is ignored.
- WB:
  - done = 1; return to IDLE.
  - Write rules:
    - ALU op or ld: R[rd] = result.
    - ci8: R[rd] = sign-extended imm8.
    - cii: R[rd] = {imm8, imm8}.
    - cup: R[rd][15:8] = imm8; low byte is kept.
    - st, bz, bnz, jr, illegal: no write.
  - Branches:
    - bz: br_taken = (opB == 0), br_target = sext(imm8).
    - bnz: br_taken = (opB != 0), br_target = sext(imm8).
    - jr (0x01): br_taken = 1, br_target = opB.
  - Unlisted op8 (anyi/ii, i2p family, invp/pp, p2i family): illegal = 1, no write.
- HALT:
  - halted = 1 and in_ready = 0 until reset.
  - Entry produces no done pulse.
- Latency, from accept edge T:
  - ALU ops: done at T+3.
  - Constants, branches, jr, illegal: done at T+2.
  - ld/st: done at the edge after the ack edge plus 1.
- Reset (rst_n = 0 at an edge):
  - State goes to IDLE; all registers, carry_flag, halted, result clear to 0.
  - All outputs 0, except in_ready = 1 after reset.
  - Mid-operation reset aborts: mem_req drops the next cycle and no writeback occurs.
- rd == rs is legal: operands are latched in DECODE, so the write in WB does not disturb them.
- dbg_data reflects a WB write from the cycle after that edge.

Decomposition:
- Shared package gr8b0nd_pkg:
  - opcode constants (4-bit and 8-bit);
  - field slice positions;
  - state enum;
  - ALU-op membership function.
- One sub-module: gr8b0nd_regfile.
  - 16x16 storage, synchronous write, one write port.
  - Three combinational read ports: rs, rd, dbg.
  - Synchronous active-low clear.

Test Plan:
- Constants: reset; issue ci8 r1 imm 0xF6, then cii r2 imm 0x0A, then cup r2 imm 0x12 -> R1 = 0xFFF6, R2 = 0x0A0A then 0x120A; each done at T+2.
- ALU addi: R1 = 9, R2 = 0; issue 0x70 rs=1 rd=2 with the ALU model attached -> alu_sel = 0x70 only in EXEC, alu_a = 9, alu_b = 0, R2 = 9 at T+3, carry_flag = 0. Then R1 = 0xFFFF, R2 = 1 -> R2 = 0, carry_flag = 1.
- Branches: R3 = 0; bz rd=3 imm 0xFC -> br_taken = 1, br_target = 0xFFFC. bnz on the same register -> br_taken = 0. jr rd=3 with R3 = 0x0040 -> br_target = 0x0040.
- Memory: ld rs=4 (R4 = 0x0100) rd=5 with ack delayed 3 cycles, rdata 0xBEEF -> mem_req held 3 cycles, addr = 0x0100, we = 0, R5 = 0xBEEF. st -> we = 1, wdata = R[rd], no register change.
- Illegal/trap: issue 0x30 -> illegal and done pulse together, no write. Then issue 0x0000 -> halted = 1, in_ready stays 0 for 20 cycles despite in_valid; rst_n = 0 clears it.
- Mid-operation reset: assert rst_n = 0 during MEM -> next cycle mem_req = 0, in_ready = 1, registers 0, no done pulse.
